// File: rtl/hazard_unit.sv
// Hazard and forwarding controller for the five-stage pipeline: load-use stalls,
// branch flushes, EX operand bypass selection and saturating stall/flush counters.
module hazard_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_AW     = 5,
    parameter int FORWARDING = 1,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_AW-1:0]     id_rs1,
    input  logic [REG_AW-1:0]     id_rs2,
    input  logic [REG_AW-1:0]     id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  ex_branch_taken,
    input  logic [DATA_WIDTH-1:0] ex_rs1_data,
    input  logic [DATA_WIDTH-1:0] ex_rs2_data,
    input  logic [DATA_WIDTH-1:0] mem_result,
    input  logic [DATA_WIDTH-1:0] wb_result,
    output logic                  stall,
    output logic                  flush_id,
    output logic                  flush_ex,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic [DATA_WIDTH-1:0] ex_opa,
    output logic [DATA_WIDTH-1:0] ex_opb,
    output logic [CNT_WIDTH-1:0]  stall_cnt,
    output logic [CNT_WIDTH-1:0]  flush_cnt
);

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_WB  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic              r_ex_valid;
    logic [REG_AW-1:0] r_ex_rs1;
    logic [REG_AW-1:0] r_ex_rs2;
    logic [REG_AW-1:0] r_ex_rd;
    logic              r_ex_regwrite;
    logic              r_ex_memread;

    logic              r_mem_valid;
    logic [REG_AW-1:0] r_mem_rd;
    logic              r_mem_regwrite;
    logic              r_mem_memread;

    logic              r_wb_valid;
    logic [REG_AW-1:0] r_wb_rd;
    logic              r_wb_regwrite;

    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic [CNT_WIDTH-1:0] r_flush_cnt;

    logic w_ex_live;
    logic w_mem_live;
    logic w_wb_live;
    logic w_ex_hits_id;
    logic w_mem_hits_id;
    logic w_taken;
    logic w_raw_stall;
    logic w_stall;
    logic w_flush_ex;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    // A live producer has rd != 0, so an id_rs of zero can never match one.
    assign w_ex_live  = r_ex_valid  & r_ex_regwrite  & (r_ex_rd  != '0);
    assign w_mem_live = r_mem_valid & r_mem_regwrite & (r_mem_rd != '0);
    assign w_wb_live  = r_wb_valid  & r_wb_regwrite  & (r_wb_rd  != '0);

    assign w_ex_hits_id  = (r_ex_rd  == id_rs1) | (r_ex_rd  == id_rs2);
    assign w_mem_hits_id = (r_mem_rd == id_rs1) | (r_mem_rd == id_rs2);

    assign w_taken = ex_branch_taken & r_ex_valid;

    always_comb begin
        w_raw_stall = 1'b0;
        if (FORWARDING != 0) begin
            w_raw_stall = id_valid & w_ex_live & r_ex_memread & w_ex_hits_id;
        end else begin
            // Regfile is write-first, so only EX and MEM producers block ID.
            w_raw_stall = id_valid & ((w_ex_live & w_ex_hits_id) |
                                      (w_mem_live & w_mem_hits_id));
        end
    end

    assign w_stall    = w_raw_stall & ~w_taken;
    assign w_flush_ex = w_stall | w_taken;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic              mem_live,
        input logic              mem_load,
        input logic [REG_AW-1:0] mem_rd,
        input logic              wb_live,
        input logic [REG_AW-1:0] wb_rd
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (FORWARDING != 0) begin
            if (mem_live && !mem_load && (mem_rd == rs)) begin
                sel = FWD_MEM;
            end else if (wb_live && (wb_rd == rs)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

    always_comb begin
        w_fwd_a = fwd_sel(r_ex_rs1, w_mem_live, r_mem_memread, r_mem_rd, w_wb_live, r_wb_rd);
        w_fwd_b = fwd_sel(r_ex_rs2, w_mem_live, r_mem_memread, r_mem_rd, w_wb_live, r_wb_rd);
    end

    always_comb begin
        ex_opa = ex_rs1_data;
        case (w_fwd_a)
            FWD_MEM: ex_opa = mem_result;
            FWD_WB:  ex_opa = wb_result;
            default: ex_opa = ex_rs1_data;
        endcase
    end

    always_comb begin
        ex_opb = ex_rs2_data;
        case (w_fwd_b)
            FWD_MEM: ex_opb = mem_result;
            FWD_WB:  ex_opb = wb_result;
            default: ex_opb = ex_rs2_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ex_valid     <= 1'b0;
            r_ex_rs1       <= '0;
            r_ex_rs2       <= '0;
            r_ex_rd        <= '0;
            r_ex_regwrite  <= 1'b0;
            r_ex_memread   <= 1'b0;
            r_mem_valid    <= 1'b0;
            r_mem_rd       <= '0;
            r_mem_regwrite <= 1'b0;
            r_mem_memread  <= 1'b0;
            r_wb_valid     <= 1'b0;
            r_wb_rd        <= '0;
            r_wb_regwrite  <= 1'b0;
        end else begin
            r_wb_valid     <= r_mem_valid;
            r_wb_rd        <= r_mem_rd;
            r_wb_regwrite  <= r_mem_regwrite;
            r_mem_valid    <= r_ex_valid;
            r_mem_rd       <= r_ex_rd;
            r_mem_regwrite <= r_ex_regwrite;
            r_mem_memread  <= r_ex_memread;
            r_ex_valid     <= id_valid & ~w_flush_ex;
            r_ex_rs1       <= id_rs1;
            r_ex_rs2       <= id_rs2;
            r_ex_rd        <= id_rd;
            r_ex_regwrite  <= id_regwrite;
            r_ex_memread   <= id_memread;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (w_taken && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
        end
    end

    assign stall     = w_stall;
    assign flush_id  = w_taken;
    assign flush_ex  = w_flush_ex;
    assign fwd_a     = w_fwd_a;
    assign fwd_b     = w_fwd_b;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: a bypassing instance and a stall-only instance
// with 2-bit counters share the ID/EX stimulus; each is held in reset while the other runs.
module tb_hazard_unit;

    localparam int DW = 32;
    localparam int AW = 5;

    localparam int S_STALL = 0, S_FID = 1, S_FEX = 2, S_FWDA = 3, S_FWDB = 4,
                   S_OPA = 5, S_OPB = 6, S_SCNT = 7, S_FCNT = 8;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    logic id_valid;
    logic [AW-1:0] id_rs1, id_rs2, id_rd;
    logic id_regwrite, id_memread, ex_branch_taken;
    logic [DW-1:0] ex_rs1_data, ex_rs2_data, mem_result, wb_result;

    logic a_stall, a_fid, a_fex;
    logic [1:0] a_fwda, a_fwdb;
    logic [DW-1:0] a_opa, a_opb;
    logic [31:0] a_scnt, a_fcnt;

    logic b_stall, b_fid, b_fex;
    logic [1:0] b_fwda, b_fwdb;
    logic [DW-1:0] b_opa, b_opb;
    logic [1:0] b_scnt, b_fcnt;

    hazard_unit #(.DATA_WIDTH(DW), .REG_AW(AW), .FORWARDING(1), .CNT_WIDTH(32)) dut_a (
        .clk(clk), .rst(rst_a), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .ex_branch_taken(ex_branch_taken), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .mem_result(mem_result), .wb_result(wb_result), .stall(a_stall), .flush_id(a_fid),
        .flush_ex(a_fex), .fwd_a(a_fwda), .fwd_b(a_fwdb), .ex_opa(a_opa), .ex_opb(a_opb),
        .stall_cnt(a_scnt), .flush_cnt(a_fcnt)
    );

    hazard_unit #(.DATA_WIDTH(DW), .REG_AW(AW), .FORWARDING(0), .CNT_WIDTH(2)) dut_b (
        .clk(clk), .rst(rst_b), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .ex_branch_taken(ex_branch_taken), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .mem_result(mem_result), .wb_result(wb_result), .stall(b_stall), .flush_id(b_fid),
        .flush_ex(b_fex), .fwd_a(b_fwda), .fwd_b(b_fwdb), .ex_opa(b_opa), .ex_opb(b_opb),
        .stall_cnt(b_scnt), .flush_cnt(b_fcnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          dut;
        int          sig;
        logic [31:0] val;
        string       name;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] get(input int d, input int s);
        logic [31:0] v;
        v = '0;
        if (d == 0) begin
            case (s)
                S_STALL: v = {31'b0, a_stall};
                S_FID:   v = {31'b0, a_fid};
                S_FEX:   v = {31'b0, a_fex};
                S_FWDA:  v = {30'b0, a_fwda};
                S_FWDB:  v = {30'b0, a_fwdb};
                S_OPA:   v = a_opa;
                S_OPB:   v = a_opb;
                S_SCNT:  v = a_scnt;
                default: v = a_fcnt;
            endcase
        end else begin
            case (s)
                S_STALL: v = {31'b0, b_stall};
                S_FID:   v = {31'b0, b_fid};
                S_FEX:   v = {31'b0, b_fex};
                S_FWDA:  v = {30'b0, b_fwda};
                S_FWDB:  v = {30'b0, b_fwdb};
                S_OPA:   v = b_opa;
                S_OPB:   v = b_opb;
                S_SCNT:  v = {30'b0, b_scnt};
                default: v = {30'b0, b_fcnt};
            endcase
        end
        return v;
    endfunction

    // Monitor: outputs are combinational, so every cycle at the falling edge it
    // retires the expectations queued for that cycle.
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] got;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_checks++;
            got = get(e.dut, e.sig);
            if (e.cyc < cyc) begin
                n_fail++;
                $display("FAIL %s: expectation not checked in its cycle (%0d vs %0d)", e.name, e.cyc, cyc);
            end else if (got !== e.val) begin
                n_fail++;
                $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", e.name, got, e.val, cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input int d, input int s, input logic [31:0] v, input string n);
        exp_t e;
        e.dut = d; e.sig = s; e.val = v; e.name = n; e.cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic set_id(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                          input logic [AW-1:0] rd, input logic rw, input logic mr);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_regwrite = rw; id_memread = mr;
    endtask

    task automatic idle(input int n);
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        repeat (n) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; ex_branch_taken = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        ex_rs1_data = 32'hAAAA_0001; ex_rs2_data = 32'hBBBB_0002;
        mem_result = 32'h0000_1234;  wb_result = 32'hDEAD_BEEF;
        repeat (2) tick();

        // Reset state with active-looking inputs
        set_id(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1);
        ex_branch_taken = 1'b1;
        expect_v(0, S_STALL, 0, "rst_stall");
        expect_v(0, S_FID, 0, "rst_flush_id");
        expect_v(0, S_FEX, 0, "rst_flush_ex");
        expect_v(0, S_FWDA, 0, "rst_fwd_a");
        expect_v(0, S_FWDB, 0, "rst_fwd_b");
        expect_v(0, S_OPA, 32'hAAAA_0001, "rst_opa");
        expect_v(0, S_OPB, 32'hBBBB_0002, "rst_opb");
        expect_v(0, S_SCNT, 0, "rst_stall_cnt");
        expect_v(0, S_FCNT, 0, "rst_flush_cnt");
        tick();
        ex_branch_taken = 1'b0; rst_a = 1'b1;
        idle(1);

        // Back-to-back ALU dependency: add x5 then addi x6,x5
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        expect_v(0, S_STALL, 0, "alu_prod_stall");
        tick();
        set_id(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0);
        expect_v(0, S_STALL, 0, "alu_cons_no_stall");
        tick();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        expect_v(0, S_FWDA, 2, "alu_fwd_a_mem");
        expect_v(0, S_OPA, 32'h0000_1234, "alu_opa_mem");
        expect_v(0, S_FWDB, 0, "alu_fwd_b_x0");
        expect_v(0, S_OPB, 32'hBBBB_0002, "alu_opb_rf");
        idle(3);

        // Load-use: lw x7 then add x8,x7,x7
        set_id(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1);
        expect_v(0, S_STALL, 0, "lu_load_stall");
        tick();
        set_id(1'b1, 5'd7, 5'd7, 5'd8, 1'b1, 1'b0);
        expect_v(0, S_STALL, 1, "lu_stall_1");
        expect_v(0, S_FEX, 1, "lu_flush_ex");
        expect_v(0, S_FID, 0, "lu_flush_id");
        expect_v(0, S_SCNT, 0, "lu_cnt_before");
        tick();
        expect_v(0, S_STALL, 0, "lu_stall_released");
        expect_v(0, S_SCNT, 1, "lu_cnt_one");
        tick();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        expect_v(0, S_FWDA, 1, "lu_fwd_a_wb");
        expect_v(0, S_FWDB, 1, "lu_fwd_b_wb");
        expect_v(0, S_OPA, 32'hDEAD_BEEF, "lu_opa_wb");
        expect_v(0, S_OPB, 32'hDEAD_BEEF, "lu_opb_wb");
        expect_v(0, S_SCNT, 1, "lu_cnt_hold");
        idle(3);

        // MEM over WB priority: two writers of x9, then consumer of x9
        set_id(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd9, 5'd3, 5'd10, 1'b1, 1'b0);
        expect_v(0, S_STALL, 0, "prio_no_stall");
        tick();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        mem_result = 32'h11; wb_result = 32'h22;
        expect_v(0, S_FWDA, 2, "prio_fwd_a");
        expect_v(0, S_OPA, 32'h11, "prio_opa");
        expect_v(0, S_FWDB, 0, "prio_fwd_b");
        expect_v(0, S_OPB, 32'hBBBB_0002, "prio_opb");
        tick();
        mem_result = 32'h0000_1234; wb_result = 32'hDEAD_BEEF;
        idle(2);

        // x0 producer (load) followed by x0 consumer
        set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd11, 1'b1, 1'b0);
        expect_v(0, S_STALL, 0, "x0_no_stall");
        tick();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        expect_v(0, S_FWDA, 0, "x0_fwd_a");
        expect_v(0, S_FWDB, 0, "x0_fwd_b");
        expect_v(0, S_OPA, 32'hAAAA_0001, "x0_opa");
        idle(3);

        // Taken branch coinciding with a load-use condition
        set_id(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0);
        ex_branch_taken = 1'b1;
        expect_v(0, S_STALL, 0, "br_stall_suppressed");
        expect_v(0, S_FID, 1, "br_flush_id");
        expect_v(0, S_FEX, 1, "br_flush_ex");
        expect_v(0, S_SCNT, 1, "br_scnt_before");
        expect_v(0, S_FCNT, 0, "br_fcnt_before");
        tick();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        expect_v(0, S_FID, 0, "br_ex_bubble_unqualified");
        expect_v(0, S_FEX, 0, "br_ex_bubble_flush_ex");
        expect_v(0, S_FCNT, 1, "br_fcnt_one");
        expect_v(0, S_SCNT, 1, "br_scnt_same");
        tick();
        ex_branch_taken = 1'b0;
        expect_v(0, S_FCNT, 1, "br_fcnt_hold");
        idle(3);
        rst_a = 1'b0;

        // Stall-only instance
        rst_b = 1'b1;
        idle(1);
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        expect_v(1, S_STALL, 0, "nf_prod_stall");
        tick();
        set_id(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0);
        expect_v(1, S_STALL, 1, "nf_stall_ex");
        expect_v(1, S_FWDA, 0, "nf_fwd_a_1");
        tick();
        expect_v(1, S_STALL, 1, "nf_stall_mem");
        expect_v(1, S_SCNT, 1, "nf_scnt_1");
        expect_v(1, S_FWDA, 0, "nf_fwd_a_2");
        expect_v(1, S_FWDB, 0, "nf_fwd_b_2");
        expect_v(1, S_OPA, 32'hAAAA_0001, "nf_opa_rf");
        tick();
        expect_v(1, S_STALL, 0, "nf_wb_no_stall");
        expect_v(1, S_SCNT, 2, "nf_scnt_2");
        idle(4);

        // Second dependency pair drives the 2-bit counter into saturation
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd5, 5'd6, 1'b1, 1'b0);
        expect_v(1, S_STALL, 1, "sat_stall_1");
        expect_v(1, S_SCNT, 2, "sat_scnt_2");
        tick();
        expect_v(1, S_STALL, 1, "sat_stall_2");
        expect_v(1, S_SCNT, 3, "sat_scnt_3");
        tick();
        expect_v(1, S_STALL, 0, "sat_release");
        expect_v(1, S_SCNT, 3, "sat_scnt_held");
        idle(4);

        // Reset pulsed during the second stall cycle
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0);
        expect_v(1, S_STALL, 1, "rstmid_stall_1");
        tick();
        rst_b = 1'b0;
        expect_v(1, S_STALL, 0, "rstmid_stall_dropped");
        expect_v(1, S_FEX, 0, "rstmid_flush_ex");
        expect_v(1, S_SCNT, 0, "rstmid_scnt");
        expect_v(1, S_FCNT, 0, "rstmid_fcnt");
        tick();
        rst_b = 1'b1;
        tick();
        expect_v(1, S_STALL, 0, "post_rst_stall");
        expect_v(1, S_SCNT, 0, "post_rst_scnt");
        idle(3);

        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
